// File: rtl/aes_key_schedule_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_ctrl
//
// Drives an external GenSubKey round-key stage to expand one AES-128 cipher
// key into the NR+1 round keys rk0..rkNR and keeps them in a register file
// with a registered read port for the cipher datapath.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   start, key_in       expansion request; key_in is sampled on acceptance
//   busy, done          expansion in progress / one-cycle pulse when rkNR lands
//   key_ready           level: all round keys valid
//   sk_valid_out        GenSubKey valid_in
//   sk_data_out         GenSubKey data_in (previous round key)
//   sk_rcon             GenSubKey Rcon as {rc, 24'h0}
//   sk_valid_in         GenSubKey valid_out
//   sk_data_in          GenSubKey data_out
//   rd_addr, rd_data    round-key read port, one-cycle latency, 0 above NR
//   dbg_state           current FSM state (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
//
// Handshake: sk_valid_out is a single-cycle request with no back-pressure;
// GenSubKey always accepts it. Its answer is a single-cycle sk_valid_in that
// is taken only in WAIT. sk_data_out and sk_rcon stay constant from the issue
// cycle until the capture edge, because GenSubKey applies Rcon
// combinationally at its output stage.
// ---------------------------------------------------------------------------
module aes_key_schedule_ctrl #(
    parameter int KEY_LEN  = 128,
    parameter int WORD_LEN = 32,
    parameter int NR       = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [KEY_LEN-1:0]  key_in,
    output logic                busy,
    output logic                done,
    output logic                key_ready,
    output logic                sk_valid_out,
    output logic [KEY_LEN-1:0]  sk_data_out,
    output logic [WORD_LEN-1:0] sk_rcon,
    input  logic                sk_valid_in,
    input  logic [KEY_LEN-1:0]  sk_data_in,
    input  logic [3:0]          rd_addr,
    output logic [KEY_LEN-1:0]  rd_data,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_e             state_q, state_d;
    logic [3:0]         round_q, round_d;
    logic [7:0]         rc_q, rc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               key_ready_q, key_ready_d;
    logic [KEY_LEN-1:0] rk_q [0:NR];
    logic [KEY_LEN-1:0] rd_data_q;

    logic               rk_we;
    logic [3:0]         rk_waddr;
    logic [KEY_LEN-1:0] rk_wdata;

    logic               in_flight;
    logic [3:0]         prev_idx;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            round_q     <= 4'd0;
            rc_q        <= 8'h01;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            rc_q        <= rc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_ready_q <= key_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        rc_d        = rc_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        key_ready_d = key_ready_q;
        rk_we       = 1'b0;
        rk_waddr    = round_q;
        rk_wdata    = sk_data_in;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    rk_we       = 1'b1;
                    rk_waddr    = 4'd0;
                    rk_wdata    = key_in;
                    round_d     = 4'd1;
                    rc_d        = 8'h01;
                    key_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion is taken from the handshake alone, so any
                // GenSubKey pipeline depth works unchanged.
                if (sk_valid_in) begin
                    rk_we = 1'b1;
                    if (round_q == LAST_ROUND) begin
                        state_d     = S_DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        key_ready_d = 1'b1;
                    end else begin
                        round_d = round_q + 4'd1;
                        rc_d    = xtime(rc_q);
                        state_d = S_ISSUE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------- round-key storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
        end else if (rk_we) begin
            rk_q[rk_waddr] <= rk_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (rd_addr <= LAST_ROUND) begin
            rd_data_q <= rk_q[rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    // ------------------------------------------------------------ outputs
    // round_q is 1..NR whenever a request is in flight, so prev_idx is valid.
    assign in_flight    = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign prev_idx     = round_q - 4'd1;
    assign sk_valid_out = (state_q == S_ISSUE);
    assign sk_data_out  = in_flight ? rk_q[prev_idx] : '0;
    assign sk_rcon      = in_flight ? {rc_q, {(WORD_LEN-8){1'b0}}} : '0;

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_ready = key_ready_q;
    assign rd_data   = rd_data_q;
    assign dbg_state = state_q;

endmodule
